hdlc_rx_checker: RTL and testbench

Synthesizable, parametrised in-system protocol checker for the HDLC Rx path. It watches the serial Rx line and the Rx status strobes, and checks three rules: flag-to-FlagDetect latency, abort-to-AbortSignal latency, and quiet status during idle. Each rule has an error pulse, a sticky bit and a saturating counter, readable by the register interface or the bench. It sits beside the Rx block, on the same signals, and stays in silicon for field diagnostics.

---
 rtl/hdlc_chk_pkg.sv | 23 ++
 rtl/hdlc_chk_satcnt.sv | 47 ++++
 rtl/hdlc_rx_checker.sv | 162 ++++++++++++++++
 tb/tb_hdlc_rx_checker.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/hdlc_chk_pkg.sv
// ============================================================================
//  Module      : hdlc_chk_pkg
//  Description : Shared types and constants for the HDLC Rx protocol checker.
//                Check identifiers index the ErrPulse / ErrSticky / ErrCnt
//                vectors of hdlc_rx_checker.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hdlc_chk_pkg;

    typedef enum logic [1:0] {
        CHK_FLAG  = 2'd0,
        CHK_ABORT = 2'd1,
        CHK_IDLE  = 2'd2
    } chk_id_e;

    localparam int         NUM_CHK      = 3;
    localparam logic [7:0] FLAG_PATTERN = 8'h7E;

endpackage

`default_nettype wire

// File: rtl/hdlc_chk_satcnt.sv
// ============================================================================
//  Module      : hdlc_chk_satcnt
//  Description : Saturating error counter with sticky bit. Clear has priority
//                over increment; the counter stops at all-ones without wrap.
//  Ports       : clk    - clock
//                rst_n  - asynchronous active-low reset
//                clr    - synchronous clear of counter and sticky bit
//                inc    - count one event
//                cnt    - counter value (CNT_W bits)
//                sticky - set by any counted event, cleared by clr/reset
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hdlc_chk_satcnt
    import hdlc_chk_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             sticky
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            sticky <= 1'b0;
        end else if (clr) begin
            cnt    <= '0;
            sticky <= 1'b0;
        end else if (inc) begin
            sticky <= 1'b1;
            if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/hdlc_rx_checker.sv
// ============================================================================
//  Module      : hdlc_rx_checker
//  Description : In-system protocol checker for the HDLC Rx path. Checks
//                flag-to-FlagDetect latency, abort-to-AbortSignal latency and
//                quiet Rx status while the line is idle. Each check has a
//                one-cycle error pulse, a sticky bit and a saturating counter.
//  Ports       : Clk, Rst (async active-low), Enable, Clr
//                Rx, Rx_FlagDetect, Rx_ValidFrame, Rx_AbortDetect,
//                Rx_AbortSignal, Rx_WrBuff, Rx_Overflow   - observed signals
//                ErrPulse[3], ErrSticky[3]                 - per-check status
//                ErrCnt[3*CNT_W]  - check i at [i*CNT_W +: CNT_W]
//  Option      : HDLC_CHK_FIRST_ERR_TS_EN adds a free-running cycle counter
//                and FirstErrTime / FirstErrId / FirstErrValid outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hdlc_rx_checker
    import hdlc_chk_pkg::*;
#(
    parameter int FLAG_LATENCY  = 2,
    parameter int ABORT_LATENCY = 1,
    parameter int IDLE_LEN      = 8,
    parameter int CNT_W         = 16
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Enable,
    input  logic                     Clr,
    input  logic                     Rx,
    input  logic                     Rx_FlagDetect,
    input  logic                     Rx_ValidFrame,
    input  logic                     Rx_AbortDetect,
    input  logic                     Rx_AbortSignal,
    input  logic                     Rx_WrBuff,
    input  logic                     Rx_Overflow,
`ifdef HDLC_CHK_FIRST_ERR_TS_EN
    output logic [31:0]              FirstErrTime,
    output logic [1:0]               FirstErrId,
    output logic                     FirstErrValid,
`endif
    output logic [NUM_CHK-1:0]       ErrPulse,
    output logic [NUM_CHK-1:0]       ErrSticky,
    output logic [NUM_CHK*CNT_W-1:0] ErrCnt
);

    localparam logic [7:0] IDLE_MAX = 8'(IDLE_LEN);

    // Only the seven newest bits need storing: together with the bit being
    // sampled they form the 8-bit window compared at the same edge.
    logic [6:0]               rx_hist;
    logic [7:0]               hist_next;
    logic                     flag_match;
    logic [FLAG_LATENCY-1:0]  flag_pipe;
    logic [ABORT_LATENCY-1:0] abort_pipe;
    logic [7:0]               idle_cnt;
    logic                     idle_full;
    logic [NUM_CHK-1:0]       viol;
    logic [NUM_CHK-1:0]       det;

    assign hist_next  = {rx_hist, Rx};
    assign flag_match = (hist_next == FLAG_PATTERN);
    assign idle_full  = (idle_cnt == IDLE_MAX);

    // Violations are judged against the inputs at the edge where the
    // pipeline tail is set; Enable gates them so a disable discards pending
    // checks immediately.
    always_comb begin
        viol            = '0;
        viol[CHK_FLAG]  = Enable && flag_pipe[FLAG_LATENCY-1] && !Rx_FlagDetect;
        viol[CHK_ABORT] = Enable && abort_pipe[ABORT_LATENCY-1] && !Rx_AbortSignal;
        viol[CHK_IDLE]  = Enable && idle_full &&
                          (Rx_ValidFrame || Rx_WrBuff || Rx_AbortSignal || Rx_Overflow);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rx_hist    <= '0;
            flag_pipe  <= '0;
            abort_pipe <= '0;
            idle_cnt   <= '0;
            det        <= '0;
            ErrPulse   <= '0;
        end else begin
            rx_hist <= hist_next[6:0];
            if (Enable) begin
                // Each armed bit walks the pipeline on its own, so overlapping
                // flags are tracked independently.
                flag_pipe[0]  <= flag_match;
                for (int i = 1; i < FLAG_LATENCY; i++) begin
                    flag_pipe[i] <= flag_pipe[i-1];
                end
                abort_pipe[0] <= Rx_AbortDetect && Rx_ValidFrame;
                for (int i = 1; i < ABORT_LATENCY; i++) begin
                    abort_pipe[i] <= abort_pipe[i-1];
                end
                if (!Rx) begin
                    idle_cnt <= '0;
                end else if (!idle_full) begin
                    idle_cnt <= idle_cnt + 8'd1;
                end
            end else begin
                flag_pipe  <= '0;
                abort_pipe <= '0;
                idle_cnt   <= '0;
            end
            // Detection is captured first, then reported one edge later.
            det      <= viol;
            ErrPulse <= det;
        end
    end

    for (genvar i = 0; i < NUM_CHK; i++) begin : g_chk
        hdlc_chk_satcnt #(
            .CNT_W (CNT_W)
        ) u_satcnt (
            .clk    (Clk),
            .rst_n  (Rst),
            .clr    (Clr),
            .inc    (det[i]),
            .cnt    (ErrCnt[i*CNT_W +: CNT_W]),
            .sticky (ErrSticky[i])
        );
    end

`ifdef HDLC_CHK_FIRST_ERR_TS_EN
    logic [31:0] cycle_cnt;
    chk_id_e     first_id;

    always_comb begin
        first_id = CHK_IDLE;
        if (det[CHK_FLAG]) begin
            first_id = CHK_FLAG;
        end else if (det[CHK_ABORT]) begin
            first_id = CHK_ABORT;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cycle_cnt     <= '0;
            FirstErrTime  <= '0;
            FirstErrId    <= '0;
            FirstErrValid <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (Clr) begin
                FirstErrTime  <= '0;
                FirstErrId    <= '0;
                FirstErrValid <= 1'b0;
            end else if (!FirstErrValid && (|det)) begin
                FirstErrTime  <= cycle_cnt;
                FirstErrId    <= first_id;
                FirstErrValid <= 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_hdlc_rx_checker.sv
// ============================================================================
//  Module      : tb_hdlc_rx_checker
//  Description : Directed self-checking bench for hdlc_rx_checker (CNT_W=2,
//                other parameters at default values).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hdlc_rx_checker;

    localparam int CW = 2;

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic          Enable = 1'b1;
    logic          Clr = 1'b0;
    logic          Rx = 1'b1;
    logic          Rx_FlagDetect = 1'b0;
    logic          Rx_ValidFrame = 1'b0;
    logic          Rx_AbortDetect = 1'b0;
    logic          Rx_AbortSignal = 1'b0;
    logic          Rx_WrBuff = 1'b0;
    logic          Rx_Overflow = 1'b0;
    logic [2:0]    ErrPulse;
    logic [2:0]    ErrSticky;
    logic [3*CW-1:0] ErrCnt;
`ifdef HDLC_CHK_FIRST_ERR_TS_EN
    logic [31:0]   FirstErrTime;
    logic [1:0]    FirstErrId;
    logic          FirstErrValid;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    hdlc_rx_checker #(
        .FLAG_LATENCY  (2),
        .ABORT_LATENCY (1),
        .IDLE_LEN      (8),
        .CNT_W         (CW)
    ) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .Enable         (Enable),
        .Clr            (Clr),
        .Rx             (Rx),
        .Rx_FlagDetect  (Rx_FlagDetect),
        .Rx_ValidFrame  (Rx_ValidFrame),
        .Rx_AbortDetect (Rx_AbortDetect),
        .Rx_AbortSignal (Rx_AbortSignal),
        .Rx_WrBuff      (Rx_WrBuff),
        .Rx_Overflow    (Rx_Overflow),
`ifdef HDLC_CHK_FIRST_ERR_TS_EN
        .FirstErrTime   (FirstErrTime),
        .FirstErrId     (FirstErrId),
        .FirstErrValid  (FirstErrValid),
`endif
        .ErrPulse       (ErrPulse),
        .ErrSticky      (ErrSticky),
        .ErrCnt         (ErrCnt)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one active edge; inputs set before the call are sampled there.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_clr();
        Clr = 1'b1;
        tick();
        Clr = 1'b0;
    endtask

    // Shift 0,1,1,1,1,1,1,0; returns just after edge k (the final 0).
    task automatic send_flag();
        Rx = 1'b0;
        tick();
        repeat (6) begin
            Rx = 1'b1;
            tick();
        end
        Rx = 1'b0;
        tick();
        Rx = 1'b1;
    endtask

    // FlagDetect is required at edge k+2; a miss is reported at edge k+3.
    task automatic flag_case(input logic give_fd, input logic clr_rep, input logic exp_pulse);
        send_flag();
        tick();                              // edge k+1
        Rx_FlagDetect = give_fd;
        tick();                              // edge k+2
        Rx_FlagDetect = 1'b0;
        check("flag_pulse_early", {29'd0, ErrPulse}, 32'd0);
        Clr = clr_rep;
        tick();                              // edge k+3
        Clr = 1'b0;
        check("flag_pulse_report", {31'd0, ErrPulse[0]}, {31'd0, exp_pulse});
        tick();                              // edge k+4
        check("flag_pulse_end", {29'd0, ErrPulse}, 32'd0);
    endtask

    // AbortSignal is required at edge a+1; a miss is reported at edge a+2.
    task automatic abort_case(input logic sig, input logic exp_pulse);
        Rx_ValidFrame  = 1'b1;
        Rx_AbortDetect = 1'b1;
        tick();                              // edge a
        Rx_AbortDetect = 1'b0;
        Rx_AbortSignal = sig;
        tick();                              // edge a+1
        Rx_AbortSignal = 1'b0;
        Rx_ValidFrame  = 1'b0;
        check("abort_pulse_early", {29'd0, ErrPulse}, 32'd0);
        tick();                              // edge a+2
        check("abort_pulse_report", {31'd0, ErrPulse[1]}, {31'd0, exp_pulse});
        tick();
        check("abort_pulse_end", {29'd0, ErrPulse}, 32'd0);
    endtask

    // Ten Rx=1 samples after a 0; WrBuff high on samples lo..hi.
    task automatic idle_case(input int lo, input int hi);
        Rx = 1'b0;
        tick();
        for (int i = 1; i <= 10; i++) begin
            Rx        = 1'b1;
            Rx_WrBuff = (i >= lo) && (i <= hi);
            tick();
        end
        Rx_WrBuff = 1'b0;
        Rx        = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #12;
        check("rst_pulse",  {29'd0, ErrPulse},  32'd0);
        check("rst_sticky", {29'd0, ErrSticky}, 32'd0);
        check("rst_cnt",    {26'd0, ErrCnt},    32'd0);
        Rst = 1'b1;
        repeat (3) tick();

        // Flag answered in time
        flag_case(1'b1, 1'b0, 1'b0);
        check("flag_ok_cnt", {26'd0, ErrCnt}, 32'd0);

        // Flag with FlagDetect withheld
        flag_case(1'b0, 1'b0, 1'b1);
        check("flag_miss_cnt",    {30'd0, ErrCnt[1:0]}, 32'd1);
        check("flag_miss_sticky", {29'd0, ErrSticky},   32'd1);

        // Abort checks (Rx held low so the idle check stays quiet)
        pulse_clr();
        Rx = 1'b0;
        repeat (2) tick();
        abort_case(1'b0, 1'b1);
        check("abort_miss_cnt", {30'd0, ErrCnt[3:2]}, 32'd1);
        abort_case(1'b1, 1'b0);
        check("abort_ok_cnt",    {30'd0, ErrCnt[3:2]}, 32'd1);
        check("abort_sticky",    {29'd0, ErrSticky},   32'd2);

        // Idle: WrBuff on samples 9-10 -> two violations
        pulse_clr();
        idle_case(9, 10);
        check("idle_pulse_a", {31'd0, ErrPulse[2]}, 32'd1);
        tick();
        check("idle_pulse_b", {31'd0, ErrPulse[2]}, 32'd1);
        tick();
        check("idle_pulse_end", {29'd0, ErrPulse}, 32'd0);
        check("idle_cnt_two",   {30'd0, ErrCnt[5:4]}, 32'd2);
        check("idle_sticky",    {29'd0, ErrSticky},   32'd4);

        // Idle: WrBuff on samples 1-7 only -> line not yet idle
        pulse_clr();
        idle_case(1, 7);
        repeat (3) tick();
        check("idle_early_cnt", {26'd0, ErrCnt}, 32'd0);

        // Saturation at 3, then Clr coincident with the sixth report
        Rx = 1'b1;
        tick();
        repeat (5) flag_case(1'b0, 1'b0, 1'b1);
        check("sat_cnt", {30'd0, ErrCnt[1:0]}, 32'd3);
        flag_case(1'b0, 1'b1, 1'b1);
        check("clr_cnt",    {26'd0, ErrCnt},    32'd0);
        check("clr_sticky", {29'd0, ErrSticky}, 32'd0);

        // Disabled checker ignores a violating flag
        Enable = 1'b0;
        flag_case(1'b0, 1'b0, 1'b0);
        Enable = 1'b1;
        check("dis_cnt", {26'd0, ErrCnt}, 32'd0);
        flag_case(1'b0, 1'b0, 1'b1);
        check("reen_cnt", {30'd0, ErrCnt[1:0]}, 32'd1);

        // Reset mid-pipeline discards the pending flag check
        send_flag();
        tick();                              // edge k+1
        Rst = 1'b0;
        #2;
        check("mid_rst_pulse",  {29'd0, ErrPulse},  32'd0);
        check("mid_rst_sticky", {29'd0, ErrSticky}, 32'd0);
        check("mid_rst_cnt",    {26'd0, ErrCnt},    32'd0);
        Rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_pulse", {29'd0, ErrPulse}, 32'd0);
        end
        check("post_rst_cnt", {26'd0, ErrCnt}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
